// File: rtl/ps2_key_tracker_pkg.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker_pkg
// Shared definitions for the PS/2 key tracker:
//   - PS/2 prefix bytes (extended E0, break F0)
//   - 2-bit parser state encodings
//   - default arrow-key scancodes and the packed default key table
//   - the parsed-code record handed from the parser to the key-state logic
// ----------------------------------------------------------------------------
package ps2_key_tracker_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Parser states
    localparam logic [1:0] ST_IDLE    = 2'd0;  // waiting for a new sequence
    localparam logic [1:0] ST_EXT     = 2'd1;  // E0 seen
    localparam logic [1:0] ST_BRK     = 2'd2;  // F0 seen
    localparam logic [1:0] ST_EXT_BRK = 2'd3;  // E0 F0 seen

    // Default arrow-key codes, {prefix, byte}
    localparam logic [15:0] KEY_LEFT  = 16'hE06B;
    localparam logic [15:0] KEY_DOWN  = 16'hE072;
    localparam logic [15:0] KEY_RIGHT = 16'hE074;
    localparam logic [15:0] KEY_UP    = 16'hE075;

    // Entry i lives in bits [16i+15:16i]: 0 left, 1 down, 2 right, 3 up.
    localparam logic [63:0] DEFAULT_KEY_CODES = {KEY_UP, KEY_RIGHT, KEY_DOWN, KEY_LEFT};

    // One completed scancode as seen by the key-state logic.
    typedef struct packed {
        logic        done;      // a full make or break code finished this cycle
        logic        is_break;  // 1 = break (release), 0 = make (press)
        logic [15:0] code;      // {prefix, byte}
    } parsed_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_code_match.sv
// ----------------------------------------------------------------------------
// ps2_code_match
// Combinational lookup of a 16-bit scancode in the tracked-key table.
// Ports:
//   code  in  16        completed code, {prefix, byte}
//   match out NUM_KEYS  one-hot; lowest matching index wins
//   hit   out 1         code matched at least one entry
// ----------------------------------------------------------------------------
module ps2_code_match
    import ps2_key_tracker_pkg::*;
#(
    parameter int                      NUM_KEYS  = 4,
    parameter logic [16*NUM_KEYS-1:0]  KEY_CODES = DEFAULT_KEY_CODES
) (
    input  logic [15:0]         code,
    output logic [NUM_KEYS-1:0] match,
    output logic                hit
);

    // NOTE: every output of an always_comb gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        match = '0;
        hit   = 1'b0;
        // Scan from the top down so the lowest matching index is written last;
        // duplicate entries above the first match can never be selected.
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (code == KEY_CODES[16*i +: 16]) begin
                match    = '0;
                match[i] = 1'b1;
                hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker
// Parses the PS/2 byte stream (E0 extended / F0 break prefixes) and keeps a
// held flag per tracked key, with one-cycle make/break pulses.
// Ports:
//   clk          in   1         system clock, rising edge
//   rst          in   1         synchronous active-high reset
//   data         in   8         received scancode byte
//   valid        in   1         one-cycle strobe qualifying data
//   pressed      out  NUM_KEYS  held flag per key
//   make_pulse   out  NUM_KEYS  pulse on released->held
//   break_pulse  out  NUM_KEYS  pulse on held->released
//   any_pressed  out  1         OR of pressed
//   last_code    out  16        most recently completed code, {prefix, byte}
//   seq_err      out  1         pulse on malformed sequence or timeout
// All outputs are registered.
// ----------------------------------------------------------------------------
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int                      NUM_KEYS       = 4,
    parameter logic [16*NUM_KEYS-1:0]  KEY_CODES      = DEFAULT_KEY_CODES,
    parameter int                      TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          data,
    input  logic                valid,
    output logic [NUM_KEYS-1:0] pressed,
    output logic [NUM_KEYS-1:0] make_pulse,
    output logic [NUM_KEYS-1:0] break_pulse,
    output logic                any_pressed,
    output logic [15:0]         last_code,
    output logic                seq_err
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]          state, state_nxt;
    logic [CNT_W-1:0]    idle_cnt;
    logic                timeout_hit;
    logic                err_nxt;
    parsed_t             parsed;
    logic [NUM_KEYS-1:0] match;
    logic                hit;
    logic [NUM_KEYS-1:0] pressed_nxt, make_nxt, break_nxt;

    // The abort fires on the idle cycle that would bring the counter to
    // TIMEOUT_CYCLES-1; a valid byte in that same cycle takes precedence.
    assign timeout_hit = (state != ST_IDLE) && !valid && ((idle_cnt + CNT_W'(1)) == CNT_LAST);

    // ---------------------------------------------------------------- parser
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        parsed    = '0;
        if (valid) begin
            case (state)
                ST_IDLE: begin
                    if (data == PS2_EXT)      state_nxt = ST_EXT;
                    else if (data == PS2_BRK) state_nxt = ST_BRK;
                    else                      parsed = '{done: 1'b1, is_break: 1'b0, code: {8'h00, data}};
                end
                ST_EXT: begin
                    // A repeated E0 is harmless; stay and wait for the key byte.
                    if (data == PS2_BRK)      state_nxt = ST_EXT_BRK;
                    else if (data != PS2_EXT) begin
                        parsed    = '{done: 1'b1, is_break: 1'b0, code: {PS2_EXT, data}};
                        state_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_nxt = ST_IDLE;
                    if (is_prefix(data)) err_nxt = 1'b1;
                    else                 parsed  = '{done: 1'b1, is_break: 1'b1, code: {8'h00, data}};
                end
                default: begin  // ST_EXT_BRK
                    state_nxt = ST_IDLE;
                    if (is_prefix(data)) err_nxt = 1'b1;
                    else                 parsed  = '{done: 1'b1, is_break: 1'b1, code: {PS2_EXT, data}};
                end
            endcase
        end else if (timeout_hit) begin
            state_nxt = ST_IDLE;
            err_nxt   = 1'b1;
        end
    end

    // ----------------------------------------------------------- key lookup
    ps2_code_match #(
        .NUM_KEYS  (NUM_KEYS),
        .KEY_CODES (KEY_CODES)
    ) u_match (
        .code  (parsed.code),
        .match (match),
        .hit   (hit)
    );

    // Repeats of an already-held key and breaks of a released key change
    // nothing, so the pulses are the match masked by the current state.
    always_comb begin
        pressed_nxt = pressed;
        make_nxt    = '0;
        break_nxt   = '0;
        if (parsed.done && hit) begin
            if (parsed.is_break) begin
                break_nxt   = match & pressed;
                pressed_nxt = pressed & ~match;
            end else begin
                make_nxt    = match & ~pressed;
                pressed_nxt = pressed | match;
            end
        end
    end

    // -------------------------------------------------------------- registers
    // NOTE: state is written with non-blocking assignments so every register
    // samples the pre-edge values and update order inside the block is irrelevant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idle_cnt    <= '0;
            pressed     <= '0;
            make_pulse  <= '0;
            break_pulse <= '0;
            any_pressed <= 1'b0;
            last_code   <= 16'h0000;
            seq_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (valid || state == ST_IDLE || timeout_hit) idle_cnt <= '0;
            else                                          idle_cnt <= idle_cnt + CNT_W'(1);
            pressed     <= pressed_nxt;
            make_pulse  <= make_nxt;
            break_pulse <= break_nxt;
            any_pressed <= |pressed_nxt;
            seq_err     <= err_nxt;
            if (parsed.done) last_code <= parsed.code;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_tracker
// Two trackers share one byte stream: dut_a uses the default key table with a
// 16-cycle timeout, dut_b has entry 0 replaced by 16'h001D and the default
// timeout. A reference model (set of seen prefixes + per-key held table)
// pushes the expected observable event for each cycle into a per-DUT queue;
// a monitor pops and compares whenever a DUT shows a pulse, seq_err or a new
// last_code, including the cycle in which it appears.
// ----------------------------------------------------------------------------
module tb_ps2_key_tracker;
    import ps2_key_tracker_pkg::*;

    localparam logic [63:0] CODES_B = {16'hE075, 16'hE074, 16'hE072, 16'h001D};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;

    logic [3:0]  pressed_a, mk_a, bk_a, pressed_b, mk_b, bk_b;
    logic        any_a, err_a, any_b, err_b;
    logic [15:0] last_a, last_b;

    ps2_key_tracker #(.NUM_KEYS(4), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .pressed(pressed_a), .make_pulse(mk_a), .break_pulse(bk_a),
        .any_pressed(any_a), .last_code(last_a), .seq_err(err_a)
    );

    ps2_key_tracker #(.NUM_KEYS(4), .KEY_CODES(CODES_B)) dut_b (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .pressed(pressed_b), .make_pulse(mk_b), .break_pulse(bk_b),
        .any_pressed(any_b), .last_code(last_b), .seq_err(err_b)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_q = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------ reference model
    typedef struct {
        int          cyc;
        logic [3:0]  pressed;
        logic [3:0]  mk;
        logic [3:0]  bk;
        logic [15:0] last;
        logic        err;
    } ev_t;

    ev_t         exp_q[2][$];
    logic [15:0] m_codes[2][4];
    int          m_timeout[2];
    logic [3:0]  m_held[2];
    logic [15:0] m_last[2];
    logic        m_e0[2], m_f0[2];
    int          m_idle[2];

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_held[k] = '0; m_last[k] = '0; m_e0[k] = 0; m_f0[k] = 0; m_idle[k] = 0;
        end
    endfunction

    // One clock cycle of input for tracker k; expected output appears at c+1.
    function automatic void model_step(input int k, input logic v, input logic [7:0] d, input int c);
        logic [3:0]  mk = '0;
        logic [3:0]  bk = '0;
        logic        err = 1'b0;
        logic [15:0] prev = m_last[k];
        logic [15:0] code;
        int          idx = -1;
        ev_t         e;
        if (v) begin
            m_idle[k] = 0;
            if (d == PS2_EXT || d == PS2_BRK) begin
                if (m_f0[k]) begin
                    err = 1'b1; m_e0[k] = 0; m_f0[k] = 0;
                end else if (d == PS2_EXT) m_e0[k] = 1;
                else                       m_f0[k] = 1;
            end else begin
                code      = {(m_e0[k] ? 8'hE0 : 8'h00), d};
                m_last[k] = code;
                for (int i = 0; i < 4; i++)
                    if (idx < 0 && m_codes[k][i] == code) idx = i;
                if (idx >= 0) begin
                    if (m_f0[k] && m_held[k][idx]) begin
                        m_held[k][idx] = 1'b0; bk[idx] = 1'b1;
                    end else if (!m_f0[k] && !m_held[k][idx]) begin
                        m_held[k][idx] = 1'b1; mk[idx] = 1'b1;
                    end
                end
                m_e0[k] = 0; m_f0[k] = 0;
            end
        end else if (m_e0[k] || m_f0[k]) begin
            m_idle[k]++;
            if (m_idle[k] == m_timeout[k] - 1) begin
                err = 1'b1; m_e0[k] = 0; m_f0[k] = 0; m_idle[k] = 0;
            end
        end
        if (mk != 0 || bk != 0 || err || m_last[k] != prev) begin
            e.cyc = c + 1; e.pressed = m_held[k]; e.mk = mk; e.bk = bk; e.last = m_last[k]; e.err = err;
            exp_q[k].push_back(e);
        end
    endfunction

    // ------------------------------------------------------------------ monitor
    logic [15:0] prev_last[2] = '{16'h0, 16'h0};

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [3:0]  p, m, b;
            logic        an, er, seen;
            logic [15:0] l;
            ev_t         e;
            p  = k == 0 ? pressed_a : pressed_b;
            m  = k == 0 ? mk_a : mk_b;
            b  = k == 0 ? bk_a : bk_b;
            an = k == 0 ? any_a : any_b;
            er = k == 0 ? err_a : err_b;
            l  = k == 0 ? last_a : last_b;
            if (!rst_q) begin
                seen = (m != 0) || (b != 0) || er || (l != prev_last[k]);
                if (seen) begin
                    if (exp_q[k].size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_event dut%0d: got pressed=%b make=%b break=%b last=%h err=%b at cycle %0d, required no event",
                                 k, p, m, b, l, er, cyc);
                    end else begin
                        e = exp_q[k].pop_front();
                        check($sformatf("event_dut%0d", k),
                              {18'b0, cyc[15:0], p, an, m, b, l, er},
                              {18'b0, e.cyc[15:0], e.pressed, |e.pressed, e.mk, e.bk, e.last, e.err});
                    end
                end else if (exp_q[k].size() != 0 && exp_q[k][0].cyc <= cyc) begin
                    e = exp_q[k].pop_front();
                    tests++; fails++;
                    $display("FAIL missing_event dut%0d: got no event at cycle %0d, required last=%h make=%b break=%b err=%b",
                             k, cyc, e.last, e.mk, e.bk, e.err);
                end
            end
            prev_last[k] = l;
        end
    end

    // ----------------------------------------------------------------- stimulus
    task automatic drive(input logic v, input logic [7:0] d);
        @(negedge clk);
        valid = v;
        data  = d;
        for (int k = 0; k < 2; k++) model_step(k, v, d, cyc);
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; data = 8'h00;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) model_step(k, 1'b0, 8'h00, cyc);
    endtask

    task automatic check_reset_values();
        check("reset_a", {pressed_a, mk_a, bk_a, any_a, last_a, err_a}, '0);
        check("reset_b", {pressed_b, mk_b, bk_b, any_b, last_b, err_b}, '0);
    endtask

    logic [7:0] pool[11] = '{8'hE0, 8'hF0, 8'h6B, 8'h72, 8'h74, 8'h75, 8'h1D, 8'h7D, 8'hAA, 8'hFA, 8'hFE};

    initial begin
        m_codes[0] = '{16'hE06B, 16'hE072, 16'hE074, 16'hE075};
        m_codes[1] = '{16'h001D, 16'hE072, 16'hE074, 16'hE075};
        m_timeout  = '{16, 1024};
        model_reset();

        do_reset();
        check_reset_values();

        // Non-extended key on dut_b entry 0: make, typematic repeat, break.
        send(8'h1D); idle(1);
        check("b_1d_held", {63'b0, pressed_b[0]}, 64'd1);
        send(8'h1D); send(8'hF0); send(8'h1D); idle(1);
        check("b_1d_released", {60'b0, pressed_b}, 64'd0);
        check("b_last_1d", {48'b0, last_b}, 64'h001D);

        // Arrow keys on dut_a: left, up, release left.
        send(8'hE0); send(8'h6B); idle(1);
        check("a_left", {60'b0, pressed_a}, 64'b0001);
        send(8'hE0); send(8'h75); idle(1);
        check("a_left_up", {60'b0, pressed_a}, 64'b1001);
        send(8'hE0); send(8'hF0); send(8'h6B); idle(1);
        check("a_up_only", {60'b0, pressed_a}, 64'b1000);
        check("a_any", {63'b0, any_a}, 64'd1);

        // Unmapped extended code and untracked unprefixed 6B.
        send(8'hE0); send(8'h7D); idle(1);
        check("a_last_e07d", {48'b0, last_a}, 64'hE07D);
        send(8'h6B); idle(1);
        check("a_6b_untracked", {44'b0, pressed_a, last_a}, {44'b0, 4'b1000, 16'h006B});

        // Malformed F0,E0 then recovery with E0,72.
        send(8'hF0); send(8'hE0); idle(1);
        check("a_seq_err", {63'b0, err_a}, 64'd1);
        send(8'hE0); send(8'h72); idle(1);
        check("a_recover_down", {60'b0, pressed_a}, 64'b1010);

        // Timeout on dut_a after a lone E0; a later 72 is an unprefixed code.
        send(8'hE0); idle(15);
        check("a_no_err_yet", {63'b0, err_a}, 64'd0);
        idle(1);
        check("a_timeout_err", {63'b0, err_a}, 64'd1);
        send(8'h72); idle(1);
        check("a_after_timeout", {44'b0, pressed_a, last_a}, {44'b0, 4'b1010, 16'h0072});

        // Hold every key, leave a partial E0 F0, then reset.
        send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); idle(1);
        check("a_all_held", {60'b0, pressed_a}, 64'b1111);
        send(8'hE0); send(8'hF0);
        do_reset();
        check_reset_values();
        send(8'h74); idle(1);
        check("a_74_no_key", {44'b0, pressed_a, last_a}, {44'b0, 4'b0000, 16'h0074});

        // Randomized traffic with occasional long gaps and resets.
        for (int n = 0; n < 700; n++) begin
            send(pool[$urandom_range(0, 10)]);
            if ($urandom_range(0, 11) == 0) idle(20);
            else                            idle($urandom_range(0, 2));
            if ($urandom_range(0, 149) == 0) do_reset();
        end

        idle(3);
        for (int k = 0; k < 2; k++)
            check($sformatf("queue_drained_dut%0d", k), 64'(exp_q[k].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
